dsp_mult_resp: RTL and testbench



---
 rtl/riscv_defines_apu.sv | 24 ++
 rtl/dsp_mult.sv | 46 ++++
 rtl/dsp_mult_resp_fifo.sv | 53 +++++
 rtl/dsp_mult_resp.sv | 145 ++++++++++++++
 tb/tb_dsp_mult_resp.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/riscv_defines_apu.sv
// APU operator encodings shared with the multiplier, plus the result stage
// record carried down the responder pipeline.
package riscv_defines_apu;

  localparam logic [2:0] MUL_MAC32 = 3'b000;
  localparam logic [2:0] MUL_MSU32 = 3'b001;
  localparam logic [2:0] MUL_I     = 3'b010;
  localparam logic [2:0] MUL_IR    = 3'b011;
  localparam logic [2:0] MUL_DOT8  = 3'b100;
  localparam logic [2:0] MUL_DOT16 = 3'b101;
  localparam logic [2:0] MUL_H     = 3'b110;

  // Widest tag any responder instance may carry; narrower tags are
  // zero-extended into the stage record.
  localparam int unsigned APU_TAG_W = 8;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [APU_TAG_W-1:0] tag;
    logic [31:0]          result;
  } dsp_mult_stage_t;

endpackage

// File: rtl/dsp_mult.sv
// Combinational dot-product multiplier: 4x8-bit or 2x16-bit lane products
// summed with an accumulator, modulo 2^32. Other operators return zero.
module dsp_mult
  import riscv_defines_apu::*;
(
  input  logic [2:0]  operator_i,
  input  logic [1:0]  dot_signed_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [31:0] op_c_i,
  output logic [31:0] result_o
);

  logic signed [17:0] p8  [4];
  logic signed [33:0] p16 [2];
  logic [31:0] dot8, dot16;

  // bit1 of dot_signed sign-extends a lanes, bit0 sign-extends b lanes
  for (genvar g = 0; g < 4; g++) begin : g_lane8
    assign p8[g] = 18'($signed({dot_signed_i[1] & op_a_i[8*g+7], op_a_i[8*g +: 8]}))
                 * 18'($signed({dot_signed_i[0] & op_b_i[8*g+7], op_b_i[8*g +: 8]}));
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane16
    assign p16[g] = 34'($signed({dot_signed_i[1] & op_a_i[16*g+15], op_a_i[16*g +: 16]}))
                  * 34'($signed({dot_signed_i[0] & op_b_i[16*g+15], op_b_i[16*g +: 16]}));
  end

  // lane sums wrap at 32 bits
  always_comb begin
    dot8  = op_c_i;
    dot16 = op_c_i;
    for (int i = 0; i < 4; i++) dot8  = dot8  + 32'(p8[i]);
    for (int i = 0; i < 2; i++) dot16 = dot16 + 32'(p16[i]);
  end

  // operator select
  always_comb begin
    case (operator_i)
      MUL_DOT8:  result_o = dot8;
      MUL_DOT16: result_o = dot16;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/dsp_mult_resp_fifo.sv
// Result FIFO. Head entry is read straight from storage flops, so the
// outputs hold while not popped. Pointers wrap at DEPTH, any DEPTH >= 1.
module dsp_mult_resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_i,
  output logic         valid_o,
  output logic [W-1:0] rd_data_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          rd_ok;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid_o   = (cnt != '0);
  assign rd_ok     = rd_i & valid_o;
  assign rd_data_o = mem[rptr];

  // storage, pointers and fill count; simultaneous write and read both honoured
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_i) begin
        mem[wptr] <= wr_data_i;
        wptr      <= ptr_nxt(wptr);
      end
      if (rd_ok) rptr <= ptr_nxt(rptr);
      case ({wr_i, rd_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dsp_mult_resp.sv
// Tagged request/response wrapper around dsp_mult. Credits (outstanding
// count vs FIFO depth) gate the grant so the never-stalling pipeline always
// finds FIFO space.
module dsp_mult_resp
  import riscv_defines_apu::*;
#(
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TAG_WIDTH   = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [2:0]           op_i,
  input  logic [31:0]          op_a_i,
  input  logic [31:0]          op_b_i,
  input  logic [31:0]          op_c_i,
  input  logic [1:0]           dot_signed_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [31:0]          result_o,
  output logic [TAG_WIDTH-1:0] rtag_o,
  output logic                 rerr_o,
  output logic                 busy_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FW = 1 + TAG_WIDTH + 32;

  logic [CW-1:0]        outstanding;
  logic                 accept, pop;

  logic                 in_vld;
  logic [2:0]           op_q;
  logic [31:0]          a_q, b_q, c_q;
  logic [1:0]           ds_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [31:0]          mult_res;
  logic                 op_ok;

  dsp_mult_stage_t      stg0, wr_stg;
  logic                 unused_tag;

  assign gnt_o  = (outstanding < CW'(FIFO_DEPTH));
  assign accept = req_i & gnt_o;
  assign pop    = rvalid_o & rready_i;
  assign busy_o = (outstanding != '0);

  // credit counter: accept takes one, pop returns one
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase
    end
  end

  // input register, loaded only on accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_vld <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      ds_q   <= '0;
      tag_q  <= '0;
    end else begin
      in_vld <= accept;
      if (accept) begin
        op_q  <= op_i;
        a_q   <= op_a_i;
        b_q   <= op_b_i;
        c_q   <= op_c_i;
        ds_q  <= dot_signed_i;
        tag_q <= tag_i;
      end
    end
  end

  dsp_mult u_mult (
    .operator_i   (op_q),
    .dot_signed_i (ds_q),
    .op_a_i       (a_q),
    .op_b_i       (b_q),
    .op_c_i       (c_q),
    .result_o     (mult_res)
  );

  assign op_ok = (op_q == MUL_DOT8) || (op_q == MUL_DOT16);

  // unsupported operators still flow through, flagged with a zero result
  always_comb begin
    stg0        = '0;
    stg0.valid  = in_vld;
    stg0.err    = ~op_ok;
    stg0.tag    = APU_TAG_W'(tag_q);
    stg0.result = op_ok ? mult_res : '0;
  end

  if (PIPE_STAGES == 1) begin : g_nopipe
    assign wr_stg = stg0;
  end else begin : g_pipe
    dsp_mult_stage_t [PIPE_STAGES-2:0] pipe_q;

    // free-running stage shift register, never stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= stg0;
        for (int i = 1; i < int'(PIPE_STAGES) - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign wr_stg = pipe_q[PIPE_STAGES-2];
  end

  // tag bits above TAG_WIDTH are always zero
  assign unused_tag = ^wr_stg.tag;

  logic [FW-1:0] fifo_q;

  dsp_mult_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_i      (wr_stg.valid),
    .wr_data_i ({wr_stg.err, wr_stg.tag[TAG_WIDTH-1:0], wr_stg.result}),
    .rd_i      (pop),
    .valid_o   (rvalid_o),
    .rd_data_o (fifo_q)
  );

  assign {rerr_o, rtag_o, result_o} = fifo_q;

endmodule

// File: tb/tb_dsp_mult_resp.sv
// Directed bench for dsp_mult_resp with default parameters.
module tb_dsp_mult_resp;
  import riscv_defines_apu::*;

  localparam int TW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          req_i = 1'b0;
  logic          gnt_o;
  logic [2:0]    op_i = '0;
  logic [31:0]   op_a_i = '0, op_b_i = '0, op_c_i = '0;
  logic [1:0]    dot_signed_i = '0;
  logic [TW-1:0] tag_i = '0;
  logic          rvalid_o;
  logic          rready_i = 1'b0;
  logic [31:0]   result_o;
  logic [TW-1:0] rtag_o;
  logic          rerr_o;
  logic          busy_o;

  int n_chk = 0;
  int n_err = 0;

  dsp_mult_resp dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .op_i(op_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i),
    .dot_signed_i(dot_signed_i), .tag_i(tag_i), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .result_o(result_o), .rtag_o(rtag_o),
    .rerr_o(rerr_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_gnt"},    32'(gnt_o),    32'd1);
    chk({nm, "_rvalid"}, 32'(rvalid_o), 32'd0);
    chk({nm, "_result"}, result_o,      32'd0);
    chk({nm, "_rtag"},   32'(rtag_o),   32'd0);
    chk({nm, "_rerr"},   32'(rerr_o),   32'd0);
    chk({nm, "_busy"},   32'(busy_o),   32'd0);
  endtask

  // single request from an idle block; result expected in cycle 3
  task automatic issue_one(input string nm, input logic [2:0] op, input logic [1:0] ds,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [TW-1:0] tg, input logic [31:0] exp_res,
                           input logic exp_err);
    req_i = 1'b1; op_i = op; dot_signed_i = ds;
    op_a_i = a; op_b_i = b; op_c_i = c; tag_i = tg; rready_i = 1'b1;
    chk({nm, "_gnt"}, 32'(gnt_o), 32'd1);
    step();
    req_i = 1'b0;
    chk({nm, "_rvalid_c1"}, 32'(rvalid_o), 32'd0);
    chk({nm, "_busy_c1"},   32'(busy_o),   32'd1);
    step();
    chk({nm, "_rvalid_c2"}, 32'(rvalid_o), 32'd0);
    step();
    chk({nm, "_rvalid_c3"}, 32'(rvalid_o), 32'd1);
    chk({nm, "_result"},    result_o,      exp_res);
    chk({nm, "_rtag"},      32'(rtag_o),   32'(tg));
    chk({nm, "_rerr"},      32'(rerr_o),   32'(exp_err));
    step();
    chk({nm, "_rvalid_c4"}, 32'(rvalid_o), 32'd0);
    chk({nm, "_busy_c4"},   32'(busy_o),   32'd0);
  endtask

  initial begin
    int grants, nt;
    int first, last, nvalid, exp_next, order_err, gnt_low;

    #1 rst_ni = 1'b0;
    #1 chk_reset_vals("por");
    #20;
    @(negedge clk_i) rst_ni = 1'b1;
    step();

    // basic arithmetic
    issue_one("dot8s",  MUL_DOT8,  2'b11, 32'h01020304, 32'hFFFFFFFF, 32'd10, 5'd3, 32'h00000000, 1'b0);
    issue_one("dot8u",  MUL_DOT8,  2'b00, 32'h01010101, 32'hFFFFFFFF, 32'd0,  5'd4, 32'h000003FC, 1'b0);
    issue_one("dot16s", MUL_DOT16, 2'b11, 32'h0002FFFF, 32'h00030005, 32'd0,  5'd5, 32'h00000001, 1'b0);
    issue_one("dot16u", MUL_DOT16, 2'b00, 32'h00020003, 32'h00040005, 32'd7,  5'd6, 32'h0000001E, 1'b0);
    issue_one("mac32",  MUL_MAC32, 2'b00, 32'd2,        32'd3,        32'd4,  5'd7, 32'h00000000, 1'b1);
    issue_one("msu32",  MUL_MSU32, 2'b11, 32'd9,        32'd9,        32'd9,  5'd8, 32'h00000000, 1'b1);

    // back-pressure: credits cap grants at the FIFO depth
    rready_i = 1'b0; req_i = 1'b1; op_i = MUL_DOT8; dot_signed_i = 2'b00;
    op_b_i = 32'h01010101; op_c_i = 32'h100;
    grants = 0; nt = 0;
    for (int k = 0; k < 8; k++) begin
      tag_i = TW'(nt); op_a_i = 32'(nt);
      if (gnt_o) begin grants++; nt++; end
      step();
    end
    req_i = 1'b0;
    chk("bp_grants",   32'(grants),   32'd4);
    chk("bp_gnt_low",  32'(gnt_o),    32'd0);
    chk("bp_rvalid",   32'(rvalid_o), 32'd1);
    chk("bp_rtag0",    32'(rtag_o),   32'd0);
    step();
    chk("bp_hold_tag", 32'(rtag_o),   32'd0);
    chk("bp_hold_res", result_o,      32'h100);
    rready_i = 1'b1;
    step();
    chk("bp_gnt_back", 32'(gnt_o),    32'd1);
    for (int k = 1; k < 4; k++) begin
      chk("bp_order_v",   32'(rvalid_o), 32'd1);
      chk("bp_order_tag", 32'(rtag_o),   32'(k));
      chk("bp_order_res", result_o,      32'h100 + 32'(k));
      step();
    end
    chk("bp_drained", 32'(rvalid_o), 32'd0);
    chk("bp_idle",    32'(busy_o),   32'd0);

    // streaming: 16 back-to-back requests, consumer always ready
    first = -1; last = -1; nvalid = 0; exp_next = 0; order_err = 0; gnt_low = 0;
    for (int c = 0; c < 22; c++) begin
      if (rvalid_o) begin
        if (first < 0) first = c;
        if (32'(rtag_o) != 32'(exp_next) || result_o != 32'(exp_next)) order_err++;
        exp_next++; nvalid++; last = c;
      end
      if (c < 16 && !gnt_o) gnt_low++;
      req_i = (c < 16); tag_i = TW'(c); op_a_i = 32'(c); op_c_i = 32'd0;
      step();
    end
    req_i = 1'b0;
    chk("st_first",   32'(first),     32'd3);
    chk("st_count",   32'(nvalid),    32'd16);
    chk("st_last",    32'(last),      32'd18);
    chk("st_order",   32'(order_err), 32'd0);
    chk("st_gnt_low", 32'(gnt_low),   32'd0);

    // reset with three requests outstanding
    rready_i = 1'b0; req_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tag_i = TW'(20 + k);
      step();
    end
    req_i = 1'b0;
    chk("rst_pre_rvalid", 32'(rvalid_o), 32'd1);
    chk("rst_pre_busy",   32'(busy_o),   32'd1);
    #3 rst_ni = 1'b0;
    #1 chk_reset_vals("rst_mid");
    step();
    rst_ni = 1'b1;
    step();
    issue_one("post_rst", MUL_DOT16, 2'b11, 32'h0002FFFF, 32'h00030005, 32'd0, 5'd9, 32'h00000001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
